// File: rtl/mdu_seq_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and
// the iteration count used by the sequencer and the pipeline hazard logic.
package mdu_seq_pkg;

    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;
    localparam int OP_DIVU  = 3;
    localparam int OP_MTHI  = 4;
    localparam int OP_MTLO  = 5;

    localparam int ITER_N = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

    function automatic logic is_iter_op(input logic [31:0] code);
        return code <= 32'(OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; with neg_i tied to the MSB it is abs().
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mdu_seq.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// 32 shift-add / restoring shift-subtract steps on magnitudes, then a sign fix-up.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write directly
// CALC  | 32 iteration steps on acc_q
// FIX   | sign correction, HI/LO update
// DONE  | one-cycle done pulse; may accept a new start
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     in1,
    input  logic [31:0]     in2,
    output logic            busy,
    output logic            done,
    output logic [31:0]     hi,
    output logic [31:0]     lo
);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      opb_q;
    logic             is_div_q, neg_res_q, neg_rem_q;
    logic             busy_q, done_q;
    logic [31:0]      hi_q, lo_q;

    logic [31:0] op_code;
    logic        sgn_op, div_op, a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum, div_rem;
    logic [31:0] div_sub;
    logic        div_ge;
    logic [63:0] fix_prod;
    logic [31:0] fix_quot, fix_rem;

    assign op_code = 32'(op);
    assign sgn_op  = (op_code == 32'(OP_MULT)) || (op_code == 32'(OP_DIV));
    assign div_op  = (op_code == 32'(OP_DIV))  || (op_code == 32'(OP_DIVU));
    assign a_neg   = sgn_op & in1[31];
    assign b_neg   = sgn_op & in2[31];

    mdu_sign_fix #(.W(32)) u_abs_a (.val_i(in1), .neg_i(a_neg), .res_o(mag_a));
    mdu_sign_fix #(.W(32)) u_abs_b (.val_i(in2), .neg_i(b_neg), .res_o(mag_b));

    mdu_sign_fix #(.W(64)) u_fix_prod (.val_i(acc_q),        .neg_i(neg_res_q), .res_o(fix_prod));
    mdu_sign_fix #(.W(32)) u_fix_quot (.val_i(acc_q[31:0]),  .neg_i(neg_res_q), .res_o(fix_quot));
    mdu_sign_fix #(.W(32)) u_fix_rem  (.val_i(acc_q[63:32]), .neg_i(neg_rem_q), .res_o(fix_rem));

    // Remainder after a successful subtract is below the divisor, so 32 bits suffice.
    always_comb begin
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        div_rem = {acc_q[63:32], acc_q[31]};
        div_ge  = div_rem >= {1'b0, opb_q};
        div_sub = div_ge ? (div_rem[31:0] - opb_q) : div_rem[31:0];
        acc_d   = acc_q;
        if (is_div_q) begin
            acc_d = {div_sub, acc_q[30:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[31:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                ST_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER_N - 1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (is_div_q) begin
                        hi_q <= fix_rem;
                        lo_q <= fix_quot;
                    end else begin
                        hi_q <= fix_prod[63:32];
                        lo_q <= fix_prod[31:0];
                    end
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start && is_iter_op(op_code)) begin
                        state_q   <= ST_CALC;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        acc_q     <= {32'd0, mag_a};
                        opb_q     <= mag_b;
                        is_div_q  <= div_op;
                        // A zero divisor keeps the all-ones quotient unsigned.
                        neg_res_q <= (a_neg ^ b_neg) && !(div_op && (in2 == 32'd0));
                        neg_rem_q <= a_neg;
                    end else if (start && (op_code == 32'(OP_MTHI))) begin
                        hi_q <= in1;
                    end else if (start && (op_code == 32'(OP_MTLO))) begin
                        lo_q <= in1;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Randomized bench for mdu_seq against an arithmetic HI/LO reference model.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in1, in2;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_seq #(.OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .in1(in1), .in2(in2), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        longint      sp;
        int          sa, sb;
        h = m_hi;
        l = m_lo;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                p  = sp;
                h  = p[63:32];
                l  = p[31:0];
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    h = a; l = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    h = 0; l = 32'h8000_0000;
                end else begin
                    sa = a; sb = b;
                    l = sa / sb;
                    h = sa % sb;
                end
            end
            3'd3: begin
                if (b == 0) begin
                    h = a; l = 32'hFFFF_FFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Entered and left at posedge+1; leaves the DUT in its DONE cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [31:0] eh, el;
        bit busy_ok, quiet_ok, hold_ok;
        model(o, a, b, eh, el);
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(posedge clk); #1;
        check_val("busy_e0", 64'(busy), 64'd1);
        check_val("done_e0", 64'(done), 64'd0);
        busy_ok = 1; quiet_ok = 1; hold_ok = 1;
        for (int i = 1; i <= 33; i++) begin
            start = inject && (i == 10);
            op    = inject ? 3'd1 : 3'($urandom_range(0, 7));
            in1   = $urandom;
            in2   = $urandom;
            @(posedge clk); #1;
            if (i < 33) begin
                if (busy !== 1'b1) busy_ok = 0;
                if (done !== 1'b0) quiet_ok = 0;
                if (hi !== m_hi || lo !== m_lo) hold_ok = 0;
            end
        end
        start = 1'b0;
        check_val("busy_calc", 64'(busy_ok), 64'd1);
        check_val("no_early_done", 64'(quiet_ok), 64'd1);
        check_val("hilo_hold", 64'(hold_ok), 64'd1);
        check_val("done_e33", 64'(done), 64'd1);
        check_val("busy_e33", 64'(busy), 64'd0);
        check_val("hi", 64'(hi), 64'(eh));
        check_val("lo", 64'(lo), 64'(el));
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk); #1;
        check_val("done_fall", 64'(done), 64'd0);
        check_val("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic mt_op(input logic [2:0] o, input logic [31:0] d);
        start = 1'b1; op = o; in1 = d; in2 = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        if (o == 3'd4) m_hi = d; else m_lo = d;
        check_val("mt_hi", 64'(hi), 64'(m_hi));
        check_val("mt_lo", 64'(lo), 64'(m_lo));
        check_val("mt_busy", 64'(busy), 64'd0);
        check_val("mt_done", 64'(done), 64'd0);
    endtask

    initial begin
        bit quiet;
        rst_n = 1'b0;
        start = 1'b1; op = 3'd5; in1 = 32'hA5A5_0001; in2 = '0;
        #3;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_hilo", {hi, lo}, 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        m_lo = 32'hA5A5_0001;
        check_val("first_accept_lo", 64'(lo), 64'(m_lo));
        start = 1'b0;
        idle_cycle();

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 0);
        check_val("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        idle_cycle();
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check_val("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        idle_cycle();
        run_op(3'd3, 32'd100, 32'd7, 0);
        check_val("divu_100_7", {hi, lo}, {32'd2, 32'd14});
        idle_cycle();
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        check_val("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        idle_cycle();
        run_op(3'd2, 32'h1234_5678, 32'd0, 0);
        check_val("div_by0", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        idle_cycle();
        run_op(3'd2, 32'h8765_4321, 32'd0, 0);
        idle_cycle();
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_val("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        idle_cycle();
        run_op(3'd2, 32'h0000_1234, 32'h8000_0000, 1);
        idle_cycle();

        mt_op(3'd4, 32'hDEAD_BEEF);
        idle_cycle();
        run_op(3'd1, 32'd3, 32'd9, 0);
        run_op(3'd3, 32'hFFFF_0000, 32'd13, 0);
        idle_cycle();

        for (int k = 6; k <= 7; k++) begin
            start = 1'b1; op = 3'(k); in1 = $urandom; in2 = $urandom;
            @(posedge clk); #1;
            start = 1'b0;
            check_val("badop_hilo", {hi, lo}, {m_hi, m_lo});
            check_val("badop_busy", 64'(busy), 64'd0);
        end

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                8: mt_op(3'd4, $urandom);
                9: mt_op(3'd5, $urandom);
                default: run_op(3'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd(), $urandom_range(0, 4) == 0);
            endcase
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        start = 1'b1; op = 3'd0; in1 = 32'hFFFF_FFFD; in2 = 32'd5;
        @(posedge clk); #1;
        check_val("abort_busy_e0", 64'(busy), 64'd1);
        for (int i = 1; i <= 19; i++) begin
            start = (i == 10);
            op = 3'd3; in1 = $urandom; in2 = $urandom;
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst_n = 1'b0;
        #2;
        m_hi = '0; m_lo = '0;
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_done", 64'(done), 64'd0);
        check_val("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        quiet = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet = 0;
        end
        check_val("abort_quiet", 64'(quiet), 64'd1);
        run_op(3'd3, 32'd100, 32'd7, 0);
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL provide parameter OP_W, default 3: width of the op field.
REQ-002 The block SHALL provide port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL provide port start, input, 1: request strobe, sampled only when accepting.
REQ-005 The block SHALL provide port op, input, OP_W: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; others are no-op.
REQ-006 The block SHALL provide port in1, input, 32: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 The block SHALL provide port in2, input, 32: multiplier or divisor.
REQ-008 The block SHALL provide port busy, output, 1: iterative operation in flight; the pipeline stalls mfhi/mflo/mult/div on it.
REQ-009 The block SHALL provide port done, output, 1: one-cycle pulse; HI/LO hold the new result.
REQ-010 The block SHALL provide ports hi and lo, output, 32 each: architectural HI/LO registers.

Function
REQ-011 The block SHALL implement states IDLE, CALC, FIX and DONE, and SHALL accept start only in IDLE or DONE.
REQ-012 On accepted start with MULT/MULTU/DIV/DIVU, the block SHALL latch operands and op and enter CALC at that edge (E0).
REQ-013 CALC SHALL execute exactly 32 iteration steps, one per edge E1..E32, then enter FIX.
REQ-014 Multiply SHALL use shift-add on a 64-bit partial product.
REQ-015 Divide SHALL use restoring shift-subtract on a 64-bit remainder/quotient register.
REQ-016 Signed ops SHALL operate on magnitudes: abs of in1 and in2, with 0x80000000 treated as magnitude 2^31.
REQ-017 FIX at edge E33 SHALL negate the product if the operand signs differ, negate the quotient if the signs differ, and give the remainder the sign of the dividend.
REQ-018 FIX at E33 SHALL write hi/lo (product: hi=upper 32, lo=lower 32; divide: hi=remainder, lo=quotient) and enter DONE.
REQ-019 done SHALL be 1 only in DONE (the cycle after E33); busy SHALL be 1 in CALC and FIX, and 0 otherwise.
REQ-020 DONE SHALL return to IDLE on the next edge unless a new start is accepted there.
REQ-021 A divisor of 0 SHALL still take 34 cycles and SHALL yield hi=in1 (unmodified) and lo=0xFFFFFFFF for both DIV and DIVU.
REQ-022 MTHI/MTLO SHALL write hi/lo from in1 at the accepting edge, with no busy and no done, and the state SHALL stay in or return to IDLE.
REQ-023 start in CALC or FIX SHALL be ignored, with no queuing; hi/lo SHALL remain unchanged until E33.
REQ-024 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL yield lo=0x80000000 and hi=0.
REQ-025 An unrecognised op with start SHALL be ignored.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, busy=0, done=0, hi=0, lo=0, and clear the iteration counter and datapath registers.
REQ-027 Reset asserted mid-CALC SHALL abort the operation with no partial result visible on hi/lo.
REQ-028 The first accepting edge SHALL be the first rising clk after rst_n deasserts.

Structure
REQ-029 Op encodings, the state encoding and the iteration count constant (32) SHALL live in a shared package used by the decoder and the hazard unit.
REQ-030 One sub-module, mdu_sign_fix, SHALL provide combinational abs and conditional negate, instantiated for operand entry and for FIX.
REQ-031 The iteration counter SHALL be 6 bits and SHALL wrap only via FIX.

Verification
REQ-032 MULT in1=0xFFFFFFFD (-3), in2=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; done high exactly in the cycle after E33; busy high E0..E33.
REQ-033 MULTU in1=in2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIV in1=0x12345678, in2=0 -> hi=0x12345678, lo=0xFFFFFFFF after 34 cycles.
REQ-036 A MULT start at E0, a second start at E10 and rst_n pulsed low at E20 -> second start ignored, hi=lo=0, busy=0, no done pulse.
REQ-037 MTHI 0xDEADBEEF in IDLE, then a DIVU start in the DONE cycle of a prior op -> hi updated next edge; back-to-back accept with busy rising at that edge.
